// File: rtl/alu_issue_stage_if.sv
// Bundle between decode, the ID/EX issue register, the forwarding sources and the ALU.
// The stage uses the slave modport; the environment driving it uses master.
interface alu_issue_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc;
    logic [XLEN-1:0]    in_rs1_data;
    logic [XLEN-1:0]    in_rs2_data;
    logic [XLEN-1:0]    in_imm;
    logic [RADDR_W-1:0] in_rs1_addr;
    logic [RADDR_W-1:0] in_rs2_addr;
    logic [RADDR_W-1:0] in_rd_addr;
    logic               in_reg_write;
    logic               in_sel_a_pc;
    logic               in_sel_b_imm;
    logic [3:0]         in_ctrl;
    logic               exm_reg_write;
    logic [RADDR_W-1:0] exm_rd_addr;
    logic [XLEN-1:0]    exm_result;
    logic               mwb_reg_write;
    logic [RADDR_W-1:0] mwb_rd_addr;
    logic [XLEN-1:0]    mwb_result;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    src_a;
    logic [XLEN-1:0]    src_b;
    logic [3:0]         ctrl;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;
    logic [XLEN-1:0]    store_data;

    modport master (
        output flush, in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_reg_write,
               in_sel_a_pc, in_sel_b_imm, in_ctrl,
               exm_reg_write, exm_rd_addr, exm_result,
               mwb_reg_write, mwb_rd_addr, mwb_result, out_ready,
        input  in_ready, out_valid, src_a, src_b, ctrl, rd_addr, reg_write, store_data
    );

    modport slave (
        input  flush, in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_reg_write,
               in_sel_a_pc, in_sel_b_imm, in_ctrl,
               exm_reg_write, exm_rd_addr, exm_result,
               mwb_reg_write, mwb_rd_addr, mwb_result, out_ready,
        output in_ready, out_valid, src_a, src_b, ctrl, rd_addr, reg_write, store_data
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register feeding the ALU: one-entry valid/ready pipe with flush and operand forwarding.
// Forwarding from EX/MEM and MEM/WB is compiled in only when ALU_ISSUE_FWD_EN is defined.
module alu_issue_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_stage_if.slave io
);
    logic               r_vld_p0;
    logic [XLEN-1:0]    r_pc_p0;
    logic [XLEN-1:0]    r_rs1_p0;
    logic [XLEN-1:0]    r_rs2_p0;
    logic [XLEN-1:0]    r_imm_p0;
    logic [RADDR_W-1:0] r_rs1_addr_p0;
    logic [RADDR_W-1:0] r_rs2_addr_p0;
    logic [RADDR_W-1:0] r_rd_addr_p0;
    logic               r_reg_write_p0;
    logic               r_sel_a_pc_p0;
    logic               r_sel_b_imm_p0;
    logic [3:0]         r_ctrl_p0;

    logic               w_in_ready;
    logic               w_accept;
    logic [XLEN-1:0]    w_fwd_rs1;
    logic [XLEN-1:0]    w_fwd_rs2;

    assign w_in_ready  = !r_vld_p0 || io.out_ready;
    assign w_accept    = io.in_valid && w_in_ready;
    assign io.in_ready = w_in_ready;

    // Decode -> issue register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0       <= 1'b0;
            r_pc_p0        <= '0;
            r_rs1_p0       <= '0;
            r_rs2_p0       <= '0;
            r_imm_p0       <= '0;
            r_rs1_addr_p0  <= '0;
            r_rs2_addr_p0  <= '0;
            r_rd_addr_p0   <= '0;
            r_reg_write_p0 <= 1'b0;
            r_sel_a_pc_p0  <= 1'b0;
            r_sel_b_imm_p0 <= 1'b0;
            r_ctrl_p0      <= '0;
        end else if (io.flush) begin
            r_vld_p0 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p0       <= 1'b1;
            r_pc_p0        <= io.in_pc;
            r_rs1_p0       <= io.in_rs1_data;
            r_rs2_p0       <= io.in_rs2_data;
            r_imm_p0       <= io.in_imm;
            r_rs1_addr_p0  <= io.in_rs1_addr;
            r_rs2_addr_p0  <= io.in_rs2_addr;
            r_rd_addr_p0   <= io.in_rd_addr;
            r_reg_write_p0 <= io.in_reg_write;
            r_sel_a_pc_p0  <= io.in_sel_a_pc;
            r_sel_b_imm_p0 <= io.in_sel_b_imm;
            r_ctrl_p0      <= io.in_ctrl;
        end else if (io.out_ready) begin
            r_vld_p0 <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_FWD_EN
    // EX/MEM wins over MEM/WB; x0 always keeps the register-file value.
    function automatic logic [XLEN-1:0] f_fwd(
        input logic [RADDR_W-1:0] rs,
        input logic [XLEN-1:0]    held,
        input logic               exm_we,
        input logic [RADDR_W-1:0] exm_rd,
        input logic [XLEN-1:0]    exm_res,
        input logic               mwb_we,
        input logic [RADDR_W-1:0] mwb_rd,
        input logic [XLEN-1:0]    mwb_res
    );
        logic [XLEN-1:0] v;
        v = held;
        if (rs != '0 && exm_we && exm_rd == rs)
            v = exm_res;
        else if (rs != '0 && mwb_we && mwb_rd == rs)
            v = mwb_res;
        return v;
    endfunction

    assign w_fwd_rs1 = f_fwd(r_rs1_addr_p0, r_rs1_p0, io.exm_reg_write, io.exm_rd_addr,
                             io.exm_result, io.mwb_reg_write, io.mwb_rd_addr, io.mwb_result);
    assign w_fwd_rs2 = f_fwd(r_rs2_addr_p0, r_rs2_p0, io.exm_reg_write, io.exm_rd_addr,
                             io.exm_result, io.mwb_reg_write, io.mwb_rd_addr, io.mwb_result);
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{r_rs1_addr_p0, r_rs2_addr_p0, io.exm_reg_write, io.exm_rd_addr,
                            io.exm_result, io.mwb_reg_write, io.mwb_rd_addr, io.mwb_result};
    assign w_fwd_rs1    = r_rs1_p0;
    assign w_fwd_rs2    = r_rs2_p0;
`endif

    // Issue register -> ALU boundary; everything reads 0 without a valid entry
    assign io.out_valid  = r_vld_p0;
    assign io.src_a      = r_vld_p0 ? (r_sel_a_pc_p0 ? r_pc_p0 : w_fwd_rs1) : '0;
    assign io.src_b      = r_vld_p0 ? (r_sel_b_imm_p0 ? r_imm_p0 : w_fwd_rs2) : '0;
    assign io.ctrl       = r_vld_p0 ? r_ctrl_p0 : '0;
    assign io.rd_addr    = r_vld_p0 ? r_rd_addr_p0 : '0;
    assign io.reg_write  = r_vld_p0 && r_reg_write_p0;
    assign io.store_data = r_vld_p0 ? w_fwd_rs2 : '0;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps then random traffic against a queue-based reference model.
// Expectations follow ALU_ISSUE_FWD_EN the same way the design does.
module tb_alu_issue_stage;
    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef struct {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1;
        logic [XLEN-1:0]    rs2;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] a1;
        logic [RADDR_W-1:0] a2;
        logic [RADDR_W-1:0] rd;
        logic               we;
        logic               sa;
        logic               sb;
        logic [3:0]         ctrl;
    } entry_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    entry_t q[$];
    logic [XLEN-1:0] exp_a;

    alu_issue_stage_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();
    alu_issue_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_fwd(input logic [RADDR_W-1:0] rs, input logic [XLEN-1:0] held);
        logic [XLEN-1:0] v;
        v = held;
`ifdef ALU_ISSUE_FWD_EN
        if (rs != 0 && bus.exm_reg_write && bus.exm_rd_addr == rs)
            v = bus.exm_result;
        else if (rs != 0 && bus.mwb_reg_write && bus.mwb_rd_addr == rs)
            v = bus.mwb_result;
`endif
        return v;
    endfunction

    task automatic check_all(input string tag);
        entry_t e;
        logic [XLEN-1:0] f1, f2;
        if (q.size() == 0) begin
            chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, 0);
            chk({tag, ".in_ready"},  {31'b0, bus.in_ready}, 1);
            chk({tag, ".src_a"},     bus.src_a, 0);
            chk({tag, ".src_b"},     bus.src_b, 0);
            chk({tag, ".ctrl"},      {28'b0, bus.ctrl}, 0);
            chk({tag, ".rd_addr"},   {27'b0, bus.rd_addr}, 0);
            chk({tag, ".reg_write"}, {31'b0, bus.reg_write}, 0);
            chk({tag, ".store"},     bus.store_data, 0);
        end else begin
            e  = q[0];
            f1 = ref_fwd(e.a1, e.rs1);
            f2 = ref_fwd(e.a2, e.rs2);
            chk({tag, ".out_valid"}, {31'b0, bus.out_valid}, 1);
            chk({tag, ".in_ready"},  {31'b0, bus.in_ready}, {31'b0, bus.out_ready});
            chk({tag, ".src_a"},     bus.src_a, e.sa ? e.pc : f1);
            chk({tag, ".src_b"},     bus.src_b, e.sb ? e.imm : f2);
            chk({tag, ".ctrl"},      {28'b0, bus.ctrl}, {28'b0, e.ctrl});
            chk({tag, ".rd_addr"},   {27'b0, bus.rd_addr}, {27'b0, e.rd});
            chk({tag, ".reg_write"}, {31'b0, bus.reg_write}, {31'b0, e.we});
            chk({tag, ".store"},     bus.store_data, f2);
        end
    endtask

    task automatic model_step();
        entry_t e;
        bit acc;
        acc = bus.in_valid && (q.size() == 0 || bus.out_ready);
        if (rst || bus.flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (acc) begin
                e.pc = bus.in_pc;        e.rs1 = bus.in_rs1_data; e.rs2 = bus.in_rs2_data;
                e.imm = bus.in_imm;      e.a1 = bus.in_rs1_addr;  e.a2 = bus.in_rs2_addr;
                e.rd = bus.in_rd_addr;   e.we = bus.in_reg_write; e.sa = bus.in_sel_a_pc;
                e.sb = bus.in_sel_b_imm; e.ctrl = bus.in_ctrl;
                q.push_back(e);
            end
        end
    endtask

    task automatic cycle(input bit do_chk, input string tag);
        #1;
        if (do_chk) check_all(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_in();
        rst = 0;                   bus.flush = 0;           bus.in_valid = 0;
        bus.in_pc = 0;             bus.in_rs1_data = 0;     bus.in_rs2_data = 0;
        bus.in_imm = 0;            bus.in_rs1_addr = 1;     bus.in_rs2_addr = 2;
        bus.in_rd_addr = 3;        bus.in_reg_write = 1;    bus.in_sel_a_pc = 0;
        bus.in_sel_b_imm = 0;      bus.in_ctrl = 0;         bus.exm_reg_write = 0;
        bus.exm_rd_addr = 9;       bus.exm_result = 0;      bus.mwb_reg_write = 0;
        bus.mwb_rd_addr = 10;      bus.mwb_result = 0;      bus.out_ready = 1;
    endtask

    task automatic rand_in();
        rst = ($urandom_range(0, 49) == 0);
        bus.flush         = ($urandom_range(0, 19) == 0);
        bus.in_valid      = ($urandom_range(0, 9) < 7);
        bus.out_ready     = ($urandom_range(0, 9) < 7);
        bus.in_pc         = $urandom;
        bus.in_rs1_data   = $urandom;
        bus.in_rs2_data   = $urandom;
        bus.in_imm        = $urandom;
        bus.in_rs1_addr   = RADDR_W'($urandom_range(0, 3));
        bus.in_rs2_addr   = RADDR_W'($urandom_range(0, 3));
        bus.in_rd_addr    = RADDR_W'($urandom);
        bus.in_reg_write  = 1'($urandom);
        bus.in_sel_a_pc   = 1'($urandom);
        bus.in_sel_b_imm  = 1'($urandom);
        bus.in_ctrl       = 4'($urandom);
        bus.exm_reg_write = 1'($urandom);
        bus.exm_rd_addr   = RADDR_W'($urandom_range(0, 3));
        bus.exm_result    = $urandom;
        bus.mwb_reg_write = 1'($urandom);
        bus.mwb_rd_addr   = RADDR_W'($urandom_range(0, 3));
        bus.mwb_result    = $urandom;
    endtask

    initial begin
        // Reset for two cycles with decode presenting work
        clear_in();
        rst = 1; bus.in_valid = 1; bus.in_rs1_data = $urandom;
        cycle(0, "rst0");
        cycle(1, "rst1");
        rst = 0; bus.in_valid = 0;
        cycle(1, "post_rst");
        chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 0);

        // Basic pass-through
        bus.in_valid = 1; bus.in_rs1_data = 32'h5; bus.in_rs2_data = 32'h3;
        cycle(1, "basic");
        chk("basic_src_a", bus.src_a, 32'h0000_0005);
        chk("basic_src_b", bus.src_b, 32'h0000_0003);
        chk("basic_valid", {31'b0, bus.out_valid}, 1);
        bus.in_valid = 0;
        cycle(1, "basic_drain");

        // PC / immediate select
        bus.in_valid = 1; bus.in_pc = 32'h1000; bus.in_imm = 32'hFFFF_FFFC;
        bus.in_sel_a_pc = 1; bus.in_sel_b_imm = 1;
        cycle(1, "sel");
        chk("sel_src_a", bus.src_a, 32'h0000_1000);
        chk("sel_src_b", bus.src_b, 32'hFFFF_FFFC);
        bus.in_valid = 0; bus.in_sel_a_pc = 0; bus.in_sel_b_imm = 0;
        cycle(1, "sel_drain");

        // Forwarding priority on a held entry
        bus.out_ready = 0; bus.in_valid = 1;
        bus.in_rs1_addr = 7; bus.in_rs1_data = 32'h1111_1111;
        cycle(1, "fwd_load");
        bus.in_valid = 0;
        bus.exm_reg_write = 1; bus.exm_rd_addr = 7; bus.exm_result = 32'hAAAA_AAAA;
        bus.mwb_reg_write = 1; bus.mwb_rd_addr = 7; bus.mwb_result = 32'hBBBB_BBBB;
        cycle(1, "fwd_exm");
`ifdef ALU_ISSUE_FWD_EN
        exp_a = 32'hAAAA_AAAA;
`else
        exp_a = 32'h1111_1111;
`endif
        chk("fwd_exm_src_a", bus.src_a, exp_a);
        bus.exm_reg_write = 0;
        cycle(1, "fwd_mwb");
`ifdef ALU_ISSUE_FWD_EN
        exp_a = 32'hBBBB_BBBB;
`else
        exp_a = 32'h1111_1111;
`endif
        chk("fwd_mwb_src_a", bus.src_a, exp_a);
        bus.exm_reg_write = 1; bus.exm_rd_addr = 0; bus.mwb_rd_addr = 0;
        bus.out_ready = 1; bus.in_valid = 1; bus.in_rs1_addr = 0; bus.in_rs1_data = 32'h2222_2222;
        cycle(1, "fwd_x0_load");
        bus.out_ready = 0; bus.in_valid = 0;
        cycle(1, "fwd_x0");
        chk("fwd_x0_src_a", bus.src_a, 32'h2222_2222);

        // Stall with new work waiting, then release
        bus.in_valid = 1; bus.in_rs1_data = 32'h3333_3333;
        for (int i = 0; i < 3; i++) begin
            cycle(1, "stall");
            chk("stall_in_ready", {31'b0, bus.in_ready}, 0);
            chk("stall_src_a", bus.src_a, 32'h2222_2222);
        end
        bus.out_ready = 1;
        cycle(1, "release");
        chk("release_src_a", bus.src_a, 32'h3333_3333);
        bus.in_valid = 0;
        cycle(1, "release_drain");
        chk("release_no_dup", {31'b0, bus.out_valid}, 0);

        // Flush while holding and accepting
        bus.out_ready = 0; bus.in_valid = 1; bus.in_rs1_data = 32'h4444_4444;
        cycle(1, "flush_load");
        bus.out_ready = 1; bus.flush = 1; bus.in_rs1_data = 32'h5555_5555;
        cycle(1, "flush");
        chk("flush_out_valid", {31'b0, bus.out_valid}, 0);
        chk("flush_reg_write", {31'b0, bus.reg_write}, 0);
        bus.flush = 0; bus.in_valid = 0;
        cycle(1, "flush_after");
        chk("flush_after_valid", {31'b0, bus.out_valid}, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            rand_in();
            cycle(1, "rand");
        end
        clear_in();
        cycle(1, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the ALU. It captures decoded operands from the decode stage and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU's src_a, src_b and ctrl inputs, plus the destination metadata that travels down the pipe.
- Uses a valid/ready handshake with stall and flush so decode and ALU can be decoupled by one entry.

Parameters:
XLEN, 32, datapath width of operands and result
RADDR_W, 5, register address width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  kill the held entry and any entry being accepted this cycle
in_valid  input  1  decode presents a valid instruction
in_ready  output  1  stage can accept this cycle
in_pc  input  XLEN  instruction PC
in_rs1_data  input  XLEN  register-file read of rs1
in_rs2_data  input  XLEN  register-file read of rs2
in_imm  input  XLEN  sign-extended immediate
in_rs1_addr  input  RADDR_W  rs1 index
in_rs2_addr  input  RADDR_W  rs2 index
in_rd_addr  input  RADDR_W  destination index
in_reg_write  input  1  instruction writes rd
in_sel_a_pc  input  1  1: src_a = pc, 0: src_a = rs1 path
in_sel_b_imm  input  1  1: src_b = imm, 0: src_b = rs2 path
in_ctrl  input  4  ALU operation code
exm_reg_write  input  1  EX/MEM stage writes a register
exm_rd_addr  input  RADDR_W  EX/MEM destination
exm_result  input  XLEN  EX/MEM result
mwb_reg_write  input  1  MEM/WB stage writes a register
mwb_rd_addr  input  RADDR_W  MEM/WB destination
mwb_result  input  XLEN  MEM/WB result
out_valid  output  1  src_a/src_b/ctrl are valid for the ALU
out_ready  input  1  downstream consumes the entry this cycle
src_a  output  XLEN  ALU operand A
src_b  output  XLEN  ALU operand B
ctrl  output  4  ALU control
rd_addr  output  RADDR_W  held destination
reg_write  output  1  held write enable, gated by out_valid
store_data  output  XLEN  forwarded rs2 value, for stores

Behaviour:
- Reset (rst=1 at clock edge):
  - out_valid=0 and all held fields = 0.
  - src_a, src_b, ctrl, rd_addr, reg_write and store_data all read 0.
- Ready: in_ready = !out_valid || out_ready (combinational, one-entry pipe). Accept = in_valid && in_ready.
- Clock-edge priority:
  - rst, then flush, then accept, then consume.
  - flush=1: out_valid <= 0 and any simultaneous accept is discarded.
  - Accept: all in_* fields are latched and out_valid <= 1.
  - Consume without accept: out_valid <= 0.
  - out_valid && !out_ready: all held fields are unchanged (stall).
- Latency: an instruction accepted at edge N is presented to the ALU after edge N. Full throughput is one instruction per cycle when out_ready=1.
- Forwarding, combinational from held registers, evaluated independently for rs1 and rs2:
  - If exm_reg_write && exm_rd_addr==rs && rs!=0, use exm_result.
  - Else if mwb_reg_write && mwb_rd_addr==rs && rs!=0, use mwb_result.
  - Else use the held register-file data.
  - EX/MEM has priority over MEM/WB.
  - Index 0 is never forwarded; the held data for x0 is used as-is.
- Operand select after forwarding:
  - src_a = sel_a_pc ? pc : fwd_rs1.
  - src_b = sel_b_imm ? imm : fwd_rs2.
  - store_data = fwd_rs2 always.
- While out_valid=0: src_a, src_b, ctrl and store_data are driven 0 and reg_write=0, so no spurious writeback.
- Widths: no arithmetic in this block. All muxing is full XLEN with no truncation.
- Reset while holding an entry: the entry is dropped and out_valid=0 on the next cycle. in_ready=1 in the cycle after reset.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- Defined: forwarding logic as above is compiled in.
- Undefined: forwarding muxes are removed.
  - fwd_rs1 = held rs1_data and fwd_rs2 = held rs2_data.
  - All exm_*/mwb_* inputs are ignored; ports remain present.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 → out_valid=0, src_a=0, src_b=0, ctrl=0, reg_write=0, in_ready=1 after reset.
- Basic pass, out_ready=1:
  - Inputs: in_rs1_data=0000_0005, in_rs2_data=0000_0003, ctrl=0000, both selects 0, no forwarding matches.
  - Required: next cycle src_a=00000005, src_b=00000003, ctrl=0000, out_valid=1.
- Immediate/PC select: pc=0000_1000, imm=FFFF_FFFC, sel_a_pc=1, sel_b_imm=1 → src_a=00001000, src_b=FFFFFFFC.
- Forwarding priority (FWD_EN defined):
  - Held rs1_addr=7, rs1_data=11111111.
  - Drive exm(7, AAAAAAAA) and mwb(7, BBBBBBBB) → src_a=AAAAAAAA.
  - Deassert exm_reg_write → src_a=BBBBBBBB.
  - Set rs1_addr=0 with the same inputs → src_a=held data.
- Stall: out_ready=0 for 3 cycles with new in_valid=1 data → in_ready=0, outputs unchanged. Raise out_ready → the next instruction appears one cycle later with no loss and no duplication.
- Flush: flush=1 in the same cycle as an accept while holding an entry → out_valid=0 next cycle and reg_write=0. Neither instruction reaches the ALU.
